// File: rtl/data_mem_pkg.sv
// Shared definitions for the MIPS data memory: geometry, access-type encodings
// and the alignment rule used by both the load and store paths.
package data_mem_pkg;

    localparam int DEPTH_WORDS = 3072;
    localparam int IDX_W       = 12;

    // First byte address past the end of storage.
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    // Access types; 3'd5..3'd7 are undefined and behave as a no-op.
    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (op)
            DM_W:        bad = (lane != 2'b00);
            DM_H, DM_HU: bad = lane[0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Store-side byte-lane merge: combines the old word with store data according
// to the access type and byte lane, and reports which lanes are written.
import data_mem_pkg::*;

module dm_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  mem_op,
    input  logic [1:0]  lane,
    output logic [31:0] merged_word,
    output logic [3:0]  byte_en
);

    logic [31:0] store_rep;

    always_comb begin
        byte_en   = 4'b0000;
        store_rep = wdata;
        case (mem_op)
            DM_W: begin
                byte_en   = 4'b1111;
                store_rep = wdata;
            end
            DM_H, DM_HU: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{wdata[15:0]}};
            end
            DM_B, DM_BU: begin
                byte_en   = 4'b0001 << lane;
                store_rep = {4{wdata[7:0]}};
            end
            default: begin
                byte_en   = 4'b0000;
                store_rep = wdata;
            end
        endcase
    end

    // Replicated store data lines up with every lane, so each byte is a simple 2:1 pick.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[i*8 +: 8] = store_rep[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data memory for the single-cycle MIPS datapath: 3072 words, byte/half/word
// access, combinational loads, synchronous clear. Define DM_TRACE_EN to log stores.
import data_mem_pkg::*;

module data_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    output logic [31:0] rdata,
    output logic        addr_err
);

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;
    logic [3:0]       byte_en;
    logic             commit;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;

    assign idx      = addr[IDX_W+1:2];
    assign lane     = addr[1:0];
    assign in_range = (addr < ADDR_LIMIT);
    assign cur_word = in_range ? mem[idx] : 32'h0;

    always_comb begin
        addr_err = 1'b0;
        case (mem_op)
            DM_W, DM_H, DM_HU, DM_B, DM_BU: addr_err = misaligned(mem_op, lane) || !in_range;
            default:                        addr_err = 1'b0;
        endcase
    end

    dm_lane_merge u_lane_merge (
        .old_word    (cur_word),
        .wdata       (wdata),
        .mem_op      (mem_op),
        .lane        (lane),
        .merged_word (merged_word),
        .byte_en     (byte_en)
    );

    // Undefined ops yield no byte enables and therefore never commit.
    assign commit = mem_write && !addr_err && (byte_en != 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= merged_word;
`ifdef DM_TRACE_EN
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
`endif
        end
    end

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    assign half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    assign byte_sel = cur_word[{lane, 3'b000} +: 8];

    always_comb begin
        rdata = 32'h0;
        case (mem_op)
            DM_W:    rdata = cur_word;
            DM_H:    rdata = {{16{half_sel[15]}}, half_sel};
            DM_HU:   rdata = {16'h0, half_sel};
            DM_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   rdata = {24'h0, byte_sel};
            default: rdata = 32'h0;
        endcase
        if (addr_err) begin
            rdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a vector table checked before each rising edge,
// then a hand-written read-during-write sequence.
module tb_data_mem;

    localparam logic [2:0] W  = 3'd0;
    localparam logic [2:0] H  = 3'd1;
    localparam logic [2:0] HU = 3'd2;
    localparam logic [2:0] B  = 3'd3;
    localparam logic [2:0] BU = 3'd4;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [31:0] rdata;
    logic        addr_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_op    (mem_op),
        .rdata     (rdata),
        .addr_err  (addr_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic add(input logic r, input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic c, input logic [31:0] er, input logic ee);
        vec_t v;
        v.rst = r; v.we = we; v.op = op; v.addr = a; v.wdata = d;
        v.chk = c; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic we, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        reset = r; mem_write = we; mem_op = op; addr = a; wdata = d; pc = p;
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [31:0] exp_rd, input logic exp_e);
        tests_run++;
        if (rdata !== exp_rd || addr_err !== exp_e) begin
            tests_failed++;
            $display("FAIL %s: got rdata=%h addr_err=%b, expected rdata=%h addr_err=%b",
                     name, rdata, addr_err, exp_rd, exp_e);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, W, 32'h0, 32'h0, 32'h0);

        // Each row: inputs, then rdata/addr_err expected just before the edge that applies them.
        add(1, 0, W,    32'h0000, 32'h0,        0, 32'h0,        0);
        add(0, 0, W,    32'h0010, 32'h0,        1, 32'h0,        0);
        add(0, 0, W,    32'h2FFC, 32'h0,        1, 32'h0,        0);
        add(0, 1, W,    32'h0010, 32'h12345678, 1, 32'h0,        0);
        add(1, 0, W,    32'h0010, 32'h0,        1, 32'h12345678, 0);
        add(0, 0, W,    32'h0010, 32'h0,        1, 32'h0,        0);
        add(0, 1, W,    32'h0020, 32'hAABBCCDD, 1, 32'h0,        0);
        add(0, 1, B,    32'h0021, 32'h00000011, 1, 32'hFFFFFFCC, 0);
        add(0, 0, W,    32'h0020, 32'h0,        1, 32'hAABB11DD, 0);
        add(0, 0, B,    32'h0023, 32'h0,        1, 32'hFFFFFFAA, 0);
        add(0, 0, BU,   32'h0023, 32'h0,        1, 32'h000000AA, 0);
        add(0, 0, H,    32'h0022, 32'h0,        1, 32'hFFFFAABB, 0);
        add(0, 0, HU,   32'h0020, 32'h0,        1, 32'h000011DD, 0);
        add(0, 0, B,    32'h0020, 32'h0,        1, 32'hFFFFFFDD, 0);
        add(0, 1, H,    32'h0042, 32'h12348001, 1, 32'h0,        0);
        add(0, 0, W,    32'h0040, 32'h0,        1, 32'h80010000, 0);
        add(0, 0, H,    32'h0042, 32'h0,        1, 32'hFFFF8001, 0);
        add(0, 0, HU,   32'h0042, 32'h0,        1, 32'h00008001, 0);
        add(0, 0, H,    32'h0040, 32'h0,        1, 32'h0,        0);
        add(0, 1, W,    32'h0004, 32'h01020304, 1, 32'h0,        0);
        add(0, 1, W,    32'h0006, 32'h55555555, 1, 32'h0,        1);
        add(0, 1, H,    32'h0041, 32'h0000FFFF, 1, 32'h0,        1);
        add(0, 1, W,    32'h3000, 32'h55555555, 1, 32'h0,        1);
        add(0, 1, B,    32'h3000, 32'h00000055, 1, 32'h0,        1);
        add(0, 0, W,    32'h0004, 32'h0,        1, 32'h01020304, 0);
        add(0, 0, W,    32'h0040, 32'h0,        1, 32'h80010000, 0);
        add(0, 1, W,    32'h2FFC, 32'hCAFEF00D, 1, 32'h0,        0);
        add(0, 0, W,    32'h2FFC, 32'h0,        1, 32'hCAFEF00D, 0);
        add(0, 0, BU,   32'h2FFF, 32'h0,        1, 32'h000000CA, 0);
        add(0, 0, B,    32'h2FFF, 32'h0,        1, 32'hFFFFFFCA, 0);
        add(0, 1, 3'd5, 32'h0020, 32'h0,        1, 32'h0,        0);
        add(0, 0, 3'd7, 32'h3000, 32'h0,        1, 32'h0,        0);
        add(0, 0, W,    32'h0020, 32'hDEADBEEF, 1, 32'hAABB11DD, 0);
        add(0, 0, W,    32'h0020, 32'h0,        1, 32'hAABB11DD, 0);
        add(0, 1, BU,   32'h0020, 32'hFFFFFF7F, 1, 32'h000000DD, 0);
        add(0, 0, W,    32'h0020, 32'h0,        1, 32'hAABB117F, 0);
        add(0, 1, HU,   32'h0022, 32'h0000BEEF, 1, 32'h0000AABB, 0);
        add(0, 0, W,    32'h0020, 32'h0,        1, 32'hBEEF117F, 0);
        add(1, 1, W,    32'h0000, 32'hFFFFFFFF, 1, 32'h0,        0);
        add(0, 0, W,    32'h0000, 32'h0,        1, 32'h0,        0);
        add(0, 0, W,    32'h0020, 32'h0,        1, 32'h0,        0);
        add(0, 0, W,    32'h2FFC, 32'h0,        1, 32'h0,        0);
        add(0, 0, W,    32'h0004, 32'h0,        1, 32'h0,        0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h0);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err);
            end
        end

        // Read during write: old contents until the edge, new contents after it.
        @(negedge clk);
        drive(1'b0, 1'b1, W, 32'h0008, 32'h00000001, 32'h00003000);
        #1;
        check("rdw_before", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("rdw_after", 32'h00000001, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, B, 32'h0008, 32'h0, 32'h0);
        #1;
        check("rdw_byte", 32'h00000001, 1'b0);

        // Neighbouring word must be untouched by the word store above.
        @(negedge clk);
        drive(1'b0, 1'b0, W, 32'h000C, 32'h0, 32'h0);
        #1;
        check("rdw_neighbour", 32'h0, 1'b0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
